// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit controller: funct3 encodings,
// FSM state type, access-size masks and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  // Unsigned variants only exist for loads; there is no zero-extending store.
  function automatic logic f3_legal(input logic [2:0] f3, input logic wren);
    logic v;
    case (f3)
      F3_B, F3_H, F3_W: v = 1'b1;
      F3_BU, F3_HU:     v = ~wren;
      default:          v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = MASK_BYTE;
      F3_H, F3_HU: m = MASK_HALF;
      F3_W:        m = MASK_WORD;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable generation across a 64-bit window,
// store-data lane positioning and load-result alignment/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_wren,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rd0,
  input  logic [31:0] i_rd1,
  output logic        o_legal,
  output logic        o_two_beat,
  output logic [7:0]  o_lanes,
  output logic [63:0] o_wd64,
  output logic [31:0] o_ld_data
);

  logic [3:0]  w_mask;
  logic [31:0] w_rd_shift;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_mask     = size_mask(i_funct3);
    o_legal    = f3_legal(i_funct3, i_wren);
    o_lanes    = {4'b0000, w_mask} << i_off;
    o_two_beat = |o_lanes[7:4];
    o_wd64     = {32'h0, i_st_data} << {i_off, 3'b000};
    // The access window spans both beats; the shift brings byte 0 of the access to bit 0.
    w_rd_shift = 32'({i_rd1, i_rd0} >> {i_off, 3'b000});
    o_ld_data  = w_rd_shift;
    case (i_funct3)
      F3_B:    o_ld_data = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
      F3_H:    o_ld_data = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
      F3_BU:   o_ld_data = {24'h0, w_rd_shift[7:0]};
      F3_HU:   o_ld_data = {16'h0, w_rd_shift[15:0]};
      default: o_ld_data = w_rd_shift;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one core request, issues one or two aligned
// memory beats (misaligned accesses split across words) and reports completion.
module lsu_ctrl
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_req,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  output logic        o_lsu_ready,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_ld_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  lsu_state_e  r_state;
  logic        r_wren;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_two_beat;
  logic [3:0]  r_be_hi;
  logic [31:0] r_wd_hi;
  logic [31:0] r_rd0;

  logic        w_idle;
  logic [2:0]  w_funct3;
  logic        w_wren;
  logic [1:0]  w_off;
  logic [31:0] w_rd0;
  logic        w_legal;
  logic        w_two_beat;
  logic [7:0]  w_lanes;
  logic [63:0] w_wd64;
  logic [31:0] w_ld_data;

  // In IDLE the aligner decodes the incoming request; afterwards the latched one.
  assign w_idle   = (r_state == IDLE);
  assign w_funct3 = w_idle ? i_funct3 : r_funct3;
  assign w_wren   = w_idle ? i_lsu_wren : r_wren;
  assign w_off    = w_idle ? i_lsu_addr[1:0] : r_off;
  assign w_rd0    = (r_state == BEAT0) ? i_mem_rdata : r_rd0;

  lsu_align u_align (
    .i_funct3   (w_funct3),
    .i_wren     (w_wren),
    .i_off      (w_off),
    .i_st_data  (i_st_data),
    .i_rd0      (w_rd0),
    .i_rd1      (i_mem_rdata),
    .o_legal    (w_legal),
    .o_two_beat (w_two_beat),
    .o_lanes    (w_lanes),
    .o_wd64     (w_wd64),
    .o_ld_data  (w_ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_wren      <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_two_beat  <= 1'b0;
      r_be_hi     <= 4'h0;
      r_wd_hi     <= 32'h0;
      r_rd0       <= 32'h0;
      o_lsu_ready <= 1'b1;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_ld_data   <= 32'h0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'h0;
      o_mem_be    <= 4'h0;
      o_mem_wdata <= 32'h0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_lsu_req && o_lsu_ready) begin
            r_wren      <= i_lsu_wren;
            r_funct3    <= i_funct3;
            r_off       <= i_lsu_addr[1:0];
            o_lsu_ready <= 1'b0;
            if (!w_legal) begin
              r_state <= DONE;
              o_done  <= 1'b1;
              o_err   <= 1'b1;
            end else begin
              r_state     <= BEAT0;
              r_two_beat  <= w_two_beat;
              r_be_hi     <= w_lanes[7:4];
              r_wd_hi     <= w_wd64[63:32];
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_lsu_wren;
              o_mem_addr  <= {i_lsu_addr[31:2], 2'b00};
              o_mem_be    <= w_lanes[3:0];
              o_mem_wdata <= w_wd64[31:0];
            end
          end
        end
        BEAT0: begin
          if (i_mem_ack) begin
            r_rd0 <= i_mem_rdata;
            if (r_two_beat) begin
              r_state     <= BEAT1;
              o_mem_addr  <= o_mem_addr + 32'd4;
              o_mem_be    <= r_be_hi;
              o_mem_wdata <= r_wd_hi;
            end else begin
              r_state   <= DONE;
              o_mem_req <= 1'b0;
              o_mem_we  <= 1'b0;
              o_done    <= 1'b1;
              if (!r_wren) o_ld_data <= w_ld_data;
            end
          end
        end
        BEAT1: begin
          if (i_mem_ack) begin
            r_state   <= DONE;
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
            o_done    <= 1'b1;
            if (!r_wren) o_ld_data <= w_ld_data;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          o_lsu_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vectors plus randomized accesses checked against
// a byte-level model of the access and a behavioural memory responder.
module tb_lsu_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_lsu_req;
  logic        i_lsu_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        o_lsu_ready;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_ld_data;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  lsu_ctrl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_lsu_req   (i_lsu_req),
    .i_lsu_wren  (i_lsu_wren),
    .i_funct3    (i_funct3),
    .i_lsu_addr  (i_lsu_addr),
    .i_st_data   (i_st_data),
    .o_lsu_ready (o_lsu_ready),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_ld_data   (o_ld_data),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  // Observations of the last operation
  logic [31:0] obs_addr [2];
  logic [3:0]  obs_be   [2];
  logic [31:0] obs_wd   [2];
  logic        obs_we   [2];
  int          obs_nb;
  int          obs_done_cyc;
  logic        obs_err;
  logic [31:0] obs_ld;

  // Model expectations
  logic [31:0] exp_addr [2];
  logic [3:0]  exp_be   [2];
  logic [31:0] exp_wd   [2];
  int          exp_nb;
  logic        exp_legal;
  logic [31:0] m_ld = 32'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-level view: byte k of the access lives at address addr+k.
  task automatic model(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] st, input logic [31:0] rd0, input logic [31:0] rd1);
    int size;
    int off;
    int k;
    int p;
    logic [31:0] val;
    logic [7:0]  bt;
    exp_legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!wren && (f3 == 3'd4 || f3 == 3'd5));
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(addr[1:0]);
    exp_nb = exp_legal ? (off + size + 3) / 4 : 0;
    for (int b = 0; b < 2; b++) begin
      exp_addr[b] = (addr & 32'hFFFF_FFFC) + 32'(4 * b);
      exp_be[b]   = 4'h0;
      exp_wd[b]   = 32'h0;
      for (int l = 0; l < 4; l++) begin
        k = 4 * b + l - off;
        if (k >= 0 && k < 4) exp_wd[b][8*l +: 8] = st[8*k +: 8];
        if (k >= 0 && k < size) exp_be[b][l] = 1'b1;
      end
    end
    val = 32'h0;
    for (int kk = 0; kk < size; kk++) begin
      p  = off + kk;
      bt = (p < 4) ? rd0[8*p +: 8] : rd1[8*(p-4) +: 8];
      val[8*kk +: 8] = bt;
    end
    if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
    if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
    if (exp_legal && !wren) m_ld = val;
  endtask

  task automatic do_op(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] st, input logic [31:0] rd0, input logic [31:0] rd1,
                       input int w0, input int w1);
    int c;
    int wl;
    bit bn;
    bit ds;
    logic [31:0] rd [2];
    int wv [2];
    rd[0] = rd0; rd[1] = rd1; wv[0] = w0; wv[1] = w1;
    obs_nb = 0; obs_done_cyc = -1; obs_err = 1'b0; obs_ld = 32'h0;
    for (int b = 0; b < 2; b++) begin
      obs_addr[b] = 32'h0; obs_be[b] = 4'h0; obs_wd[b] = 32'h0; obs_we[b] = 1'b0;
    end
    @(negedge i_clk);
    check("ready_before_req", o_lsu_ready, 1'b1);
    i_lsu_req   = 1'b1;
    i_lsu_wren  = wren;
    i_funct3    = f3;
    i_lsu_addr  = addr;
    i_st_data   = st;
    i_mem_ack   = 1'($urandom_range(0, 1));
    i_mem_rdata = $urandom;
    @(posedge i_clk);
    #1;
    i_lsu_req  = 1'b0;
    i_lsu_wren = 1'($urandom_range(0, 1));
    i_funct3   = 3'($urandom_range(0, 7));
    i_lsu_addr = $urandom;
    i_st_data  = $urandom;
    i_mem_ack  = 1'b0;
    c = 0; wl = w0; bn = 1'b1; ds = 1'b0;
    while (!ds && c < 40) begin
      @(negedge i_clk);
      c++;
      i_mem_ack   = 1'b0;
      i_mem_rdata = $urandom;
      if (o_done) begin
        ds = 1'b1;
        obs_done_cyc = c;
        obs_err = o_err;
        obs_ld  = o_ld_data;
        check("req_low_in_done", o_mem_req, 1'b0);
        i_mem_ack = 1'($urandom_range(0, 1));
      end else if (o_mem_req) begin
        if (obs_nb < 2) begin
          if (bn) begin
            obs_addr[obs_nb] = o_mem_addr;
            obs_be[obs_nb]   = o_mem_be;
            obs_wd[obs_nb]   = o_mem_wdata;
            obs_we[obs_nb]   = o_mem_we;
            bn = 1'b0;
          end else begin
            check("hold_addr",  o_mem_addr,  obs_addr[obs_nb]);
            check("hold_be",    o_mem_be,    obs_be[obs_nb]);
            check("hold_wdata", o_mem_wdata, obs_wd[obs_nb]);
          end
          if (wl > 0) begin
            wl--;
          end else begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = rd[obs_nb];
            obs_nb++;
            bn = 1'b1;
            if (obs_nb < 2) wl = wv[obs_nb];
          end
        end else begin
          obs_nb++;
        end
      end
    end
    check("done_seen", ds, 1'b1);
    model(wren, f3, addr, st, rd0, rd1);
    check("beats", obs_nb, exp_nb);
    check("err", obs_err, !exp_legal);
    check("latency", obs_done_cyc, exp_legal ? (exp_nb + w0 + ((exp_nb == 2) ? w1 : 0) + 1) : 1);
    for (int b = 0; b < 2; b++) begin
      if (b < exp_nb) begin
        check("beat_addr",  obs_addr[b], exp_addr[b]);
        check("beat_be",    obs_be[b],   exp_be[b]);
        check("beat_wdata", obs_wd[b],   exp_wd[b]);
        check("beat_we",    obs_we[b],   wren);
      end
    end
    check("ld_data_at_done", obs_ld, m_ld);
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    check("ready_after", o_lsu_ready, 1'b1);
    check("done_one_cycle", o_done, 1'b0);
    check("ld_data_hold", o_ld_data, m_ld);
  endtask

  initial begin
    logic [2:0]  f3_tab [10];
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] saved_ld;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

    i_reset = 1'b0; i_lsu_req = 1'b0; i_lsu_wren = 1'b0; i_funct3 = 3'd0;
    i_lsu_addr = 32'h0; i_st_data = 32'h0; i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    repeat (2) @(negedge i_clk);
    check("rst_mem_req",   o_mem_req,   1'b0);
    check("rst_mem_we",    o_mem_we,    1'b0);
    check("rst_done",      o_done,      1'b0);
    check("rst_err",       o_err,       1'b0);
    check("rst_mem_addr",  o_mem_addr,  32'h0);
    check("rst_mem_be",    o_mem_be,    4'h0);
    check("rst_mem_wdata", o_mem_wdata, 32'h0);
    check("rst_ld_data",   o_ld_data,   32'h0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("ready_after_release", o_lsu_ready, 1'b1);

    // LW aligned, zero wait
    do_op(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check("lw_be",      obs_be[0],    4'b1111);
    check("lw_latency", obs_done_cyc, 2);
    check("lw_data",    obs_ld,       32'hDEAD_BEEF);

    // LB / LBU at byte 3
    do_op(1'b0, 3'b000, 32'h0000_0013, 32'h0, 32'h8012_3456, 32'h0, 0, 0);
    check("lb_be",   obs_be[0], 4'b1000);
    check("lb_data", obs_ld,    32'hFFFF_FF80);
    do_op(1'b0, 3'b100, 32'h0000_0013, 32'h0, 32'h8012_3456, 32'h0, 1, 0);
    check("lbu_data", obs_ld, 32'h0000_0080);

    // Misaligned SW split over two words
    do_op(1'b1, 3'b010, 32'h0000_0022, 32'hAABB_CCDD, 32'h0, 32'h0, 0, 0);
    check("sw_addr0",   obs_addr[0],  32'h0000_0020);
    check("sw_be0",     obs_be[0],    4'b1100);
    check("sw_wd0",     obs_wd[0],    32'hCCDD_0000);
    check("sw_addr1",   obs_addr[1],  32'h0000_0024);
    check("sw_be1",     obs_be[1],    4'b0011);
    check("sw_wd1",     obs_wd[1],    32'h0000_AABB);
    check("sw_latency", obs_done_cyc, 3);
    check("sw_ld_kept", o_ld_data,    32'h0000_0080);

    // LH wrapping past the top of the address space
    do_op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 32'h1200_0000, 32'h0000_0034, 0, 2);
    check("lh_wrap_addr1", obs_addr[1], 32'h0000_0000);
    check("lh_wrap_data",  obs_ld,      32'h0000_3412);

    // Illegal funct3
    saved_ld = o_ld_data;
    do_op(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h5555_5555, 32'h0, 0, 0);
    check("ill_no_req",  obs_nb,       0);
    check("ill_err",     obs_err,      1'b1);
    check("ill_latency", obs_done_cyc, 1);
    check("ill_ld_kept", o_ld_data,    saved_ld);

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      f3 = f3_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else addr = $urandom;
      do_op(1'($urandom_range(0, 1)), f3, addr, $urandom, $urandom, $urandom,
            $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset during BEAT0 with the ack withheld
    @(negedge i_clk);
    i_lsu_req = 1'b1; i_lsu_wren = 1'b0; i_funct3 = 3'b010; i_lsu_addr = 32'h0000_0040;
    @(posedge i_clk);
    #1 i_lsu_req = 1'b0;
    @(negedge i_clk);
    check("abort_req_before", o_mem_req, 1'b1);
    #2 i_reset = 1'b0;
    #1;
    check("abort_req_drop", o_mem_req, 1'b0);
    check("abort_no_done",  o_done,    1'b0);
    repeat (2) begin
      @(negedge i_clk);
      check("abort_hold_no_done", o_done, 1'b0);
    end
    i_reset = 1'b1;
    m_ld = 32'h0;
    @(negedge i_clk);
    check("abort_ready", o_lsu_ready, 1'b1);
    check("abort_no_req", o_mem_req, 1'b0);
    do_op(1'b0, 3'b010, 32'h0000_0080, 32'h0, 32'h1357_9BDF, 32'h0, 1, 0);
    check("post_abort_lw", obs_ld, 32'h1357_9BDF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port i_lsu_req, input, 1 bit: core requests a load or store.
REQ-004 The block SHALL have port i_lsu_wren, input, 1 bit: 1 = store, 0 = load.
REQ-005 The block SHALL have port i_funct3, input, 3 bits: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-006 The block SHALL have port i_lsu_addr, input, 32 bits: byte address.
REQ-007 The block SHALL have port i_st_data, input, 32 bits: store data, LSB-aligned.
REQ-008 The block SHALL have port o_lsu_ready, output, 1 bit: the block can accept a request.
REQ-009 The block SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port o_err, output, 1 bit: pulses with o_done for an illegal funct3.
REQ-011 The block SHALL have port o_ld_data, output, 32 bits: extended load result.
REQ-012 The block SHALL have port o_mem_req, output, 1 bit: memory-side request.
REQ-013 The block SHALL have port o_mem_we, output, 1 bit: memory-side write enable.
REQ-014 The block SHALL have port o_mem_addr, output, 32 bits: word-aligned address, bits [1:0] = 0.
REQ-015 The block SHALL have port o_mem_be, output, 4 bits: byte-lane enables.
REQ-016 The block SHALL have port o_mem_wdata, output, 32 bits: lane-positioned write data.
REQ-017 The block SHALL have port i_mem_ack, input, 1 bit: responder completes the current beat.
REQ-018 The block SHALL have port i_mem_rdata, input, 32 bits: read data, valid in the i_mem_ack cycle.

Function
REQ-019 The block SHALL implement FSM states IDLE, BEAT0, BEAT1 and DONE; o_lsu_ready SHALL be 1 only in IDLE.
REQ-020 The block SHALL register the request inputs when i_lsu_req && o_lsu_ready; the FSM SHALL then go IDLE->BEAT0, or IDLE->DONE with o_err set if funct3 is illegal (no memory access).
REQ-021 Size mask SHALL be byte 0001, half 0011, word 1111; lanes64 = mask << addr[1:0]; beat0 o_mem_be = lanes64[3:0], beat1 o_mem_be = lanes64[7:4].
REQ-022 Two beats SHALL be used only if lanes64[7:4] != 0, i.e. a halfword at offset 3 or a word at offset 1, 2 or 3.
REQ-023 Beat0 address SHALL be {addr[31:2],2'b00}; beat1 address SHALL be beat0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-024 Write data SHALL be formed as wd64 = st_data << (8*addr[1:0]); beat0 drives wd64[31:0], beat1 drives wd64[63:32].
REQ-025 o_mem_req SHALL be 1 in BEAT0 and BEAT1; o_mem_addr, o_mem_be, o_mem_we and o_mem_wdata SHALL be held stable until i_mem_ack.
REQ-026 On i_mem_ack the FSM SHALL go BEAT0->BEAT1 if two beats are needed, otherwise to DONE; BEAT1->DONE.
REQ-027 i_mem_ack SHALL be ignored in IDLE and DONE.
REQ-028 Loads SHALL capture i_mem_rdata per beat; the result SHALL be ({rd1,rd0} >> 8*addr[1:0]) truncated to the access size, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-029 DONE SHALL last exactly one cycle, pulse o_done, update o_ld_data for loads only, and return to IDLE.
REQ-030 o_ld_data SHALL hold its value between loads; stores and errors SHALL leave it unchanged.
REQ-031 Latency SHALL be: with zero-wait ack, accept cycle N gives o_done at N+2 (one beat) or N+3 (two beats); each wait cycle adds 1.
REQ-032 A new request SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-033 While i_reset = 0 the block SHALL, asynchronously: state = IDLE; o_mem_req, o_mem_we, o_done, o_err = 0; o_mem_addr, o_mem_be, o_mem_wdata, o_ld_data = 0; o_lsu_ready = 1 after release.
REQ-034 Reset during BEAT0 or BEAT1 SHALL abort the transaction, drop o_mem_req in the same cycle, and produce no o_done.

Structure
REQ-035 The funct3 encodings, the state enum and the size masks SHALL live in the shared package lsu_pkg.
REQ-036 Lane shifting, byte-enable generation and load extension SHALL be placed in one combinational sub-module, lsu_align; lsu_ctrl SHALL hold the FSM and registers.

Verification
REQ-037 LW at 0x10, rdata 0xDEADBEEF, zero-wait ack -> one beat, be 1111, o_done at N+2, o_ld_data = 0xDEADBEEF.
REQ-038 LB at 0x13, rdata 0x80123456 -> be 1000, o_ld_data = 0xFFFFFF80; LBU at the same address -> o_ld_data = 0x00000080.
REQ-039 SW at 0x22, data 0xAABBCCDD -> beat0 addr 0x20, be 1100, wdata 0xCCDD0000; beat1 addr 0x24, be 0011, wdata 0x0000AABB; o_done at N+3.
REQ-040 LH at 0xFFFFFFFF, rdata 0x12000000 then 0x00000034 -> beat1 addr 0x00000000, o_ld_data = 0x00003412.
REQ-041 funct3 = 011 -> no o_mem_req, o_done and o_err pulse at N+1, o_ld_data unchanged.
REQ-042 Assert reset in BEAT0 with the ack withheld -> o_mem_req = 0 immediately, no o_done; after release, o_lsu_ready = 1 and the next LW completes normally.
